// File: rtl/mult88_share_arb.sv
// mult88_share_arb: round-robin sharing of one pipelined 88x88 multiplier among NREQ requesters,
// with a tag pipeline routing each product to its owner. Define MULT88_SHARE_ARB_PRIO0_EN to give requester 0 fixed top priority.
module mult88_share_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 15,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*88-1:0] a,
  input  logic [NREQ*88-1:0] b,
  output logic [NREQ-1:0]   ack,
  output logic [175:0]      res,
  output logic [NREQ-1:0]   res_vld,
  input  logic [NREQ-1:0]   res_rdy,
  output logic              mul_ce,
  output logic [87:0]       mul_a,
  output logic [87:0]       mul_b,
  input  logic [175:0]      mul_o,
  output logic              busy
);

  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  logic [LAT-1:0]          tag_vld;
  logic [LAT-1:0][IDW-1:0] tag_id;
  logic [IDW-1:0]          ptr;
  logic [IDW-1:0]          ptr_nxt;
  logic [IDW-1:0]          grant_id;
  logic [IDW-1:0]          cand;
  logic [NREQ-1:0]         rr_req;
  logic                    grant_any;
  logic                    ptr_upd;
  logic                    tail_vld;
  logic [IDW-1:0]          tail_id;
  logic                    stall;

  assign tail_vld = tag_vld[LAT-1];
  assign tail_id  = tag_id[LAT-1];
  assign stall    = tail_vld & ~res_rdy[tail_id];
  assign mul_ce   = ~stall;
  assign busy     = |tag_vld;
  assign res      = mul_o;
  assign res_vld  = tail_vld ? (ONE_HOT0 << tail_id) : {NREQ{1'b0}};

  // Arbitration: first request at or after the pointer, wrapping at NREQ-1; blocked while frozen.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = {IDW{1'b0}};
    ptr_upd   = 1'b0;
    cand      = ptr;
`ifdef MULT88_SHARE_ARB_PRIO0_EN
    rr_req = req & ~ONE_HOT0;
`else
    rr_req = req;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && rr_req[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end else begin
        grant_any = grant_any;
      end
      cand = (cand == LAST_ID) ? {IDW{1'b0}} : cand + IDW'(1);
    end
    ptr_upd = grant_any;
`ifdef MULT88_SHARE_ARB_PRIO0_EN
    // Requester 0 overrides the rotation and leaves the pointer untouched.
    if (req[0]) begin
      grant_any = 1'b1;
      grant_id  = {IDW{1'b0}};
      ptr_upd   = 1'b0;
    end else begin
      ptr_upd = grant_any;
    end
`endif
    if (!mul_ce) begin
      grant_any = 1'b0;
      ptr_upd   = 1'b0;
    end else begin
      ptr_upd = ptr_upd;
    end
  end

  assign ptr_nxt = (grant_id == LAST_ID) ? {IDW{1'b0}} : grant_id + IDW'(1);
  assign ack     = grant_any ? (ONE_HOT0 << grant_id) : {NREQ{1'b0}};
  assign mul_a   = a[int'(grant_id)*88 +: 88];
  assign mul_b   = b[int'(grant_id)*88 +: 88];

  // Tag pipeline and pointer advance only on enabled cycles, in lockstep with the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= {LAT{1'b0}};
      tag_id  <= '0;
      ptr     <= {IDW{1'b0}};
    end else if (mul_ce) begin
      tag_vld <= {tag_vld[LAT-2:0], grant_any};
      tag_id  <= {tag_id[LAT-2:0], grant_id};
      if (ptr_upd) begin
        ptr <= ptr_nxt;
      end
    end
  end

endmodule
